// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner: the blank pattern,
// the hex-to-segment mapping and the digit-index width rule.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble-to-segment decoder with a blank override.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : hex2seg(i_nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-synchronous
// double buffering. Optional anode PWM dimming is built when SSD_DIMMING_EN is defined.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
`ifdef SSD_DIMMING_EN
  input  logic [3:0]              brightness,
`endif
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_index;
  logic [4*NUM_DIGITS-1:0] r_sh_hex, r_act_hex;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank, r_act_blank;
  logic                    r_sh_valid, r_act_valid;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_tick;

  logic                    w_slot_end;
  logic                    w_boundary;
  logic                    w_pwm_on;
  logic [3:0]              w_nibbles [NUM_DIGITS];
  logic [3:0]              w_nibble;
  logic                    w_blank_bit;
  logic                    w_dp_bit;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  logic [NUM_DIGITS-1:0]   w_an_on;

  assign w_slot_end = (r_presc == PRE_LAST);
  assign w_boundary = w_slot_end && (r_index == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_index <= '0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
      if (w_slot_end)
        r_index <= (r_index == IDX_LAST) ? '0 : r_index + 1'b1;
    end
  end

  // Load on the boundary cycle bypasses the shadow so there is no one-frame lag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_hex    <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '1;
      r_sh_valid  <= 1'b0;
      r_act_hex   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '1;
      r_act_valid <= 1'b0;
    end else begin
      if (load) begin
        r_sh_hex   <= hex_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
        r_sh_valid <= 1'b1;
      end
      if (w_boundary) begin
        r_act_hex   <= load ? hex_in   : r_sh_hex;
        r_act_dp    <= load ? dp_in    : r_sh_dp;
        r_act_blank <= load ? blank_in : r_sh_blank;
        r_act_valid <= load | r_sh_valid;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nibbles[gi] = r_act_hex[4*gi +: 4];
      assign w_an_sel[gi]  = (r_index == IDX_W'(gi));
    end
  endgenerate

  assign w_nibble    = w_nibbles[r_index];
  assign w_blank_bit = r_act_blank[r_index];
  assign w_dp_bit    = r_act_dp[r_index];

  seven_seg_hex_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank_bit),
    .o_seg    (w_seg)
  );

`ifdef SSD_DIMMING_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_pwm_cnt <= '0;
    else     r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  assign w_pwm_on = (r_pwm_cnt <= brightness);
`else
  assign w_pwm_on = 1'b1;
`endif

  // Anodes stay dark until a load has reached the active register
  assign w_an_on = w_an_sel & {NUM_DIGITS{r_act_valid & w_pwm_on}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg;
      r_dp         <= ~(w_dp_bit & ~w_blank_bit);
      r_an         <= (ANODE_ACTIVE_LOW != 0) ? ~w_an_on : w_an_on;
      r_frame_tick <= w_boundary;
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign an_out     = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (NUM_DIGITS=4, REFRESH_DIV=4):
// per-cycle reference model plus table vectors and hand-written corner sequences.
module tb_seven_segment_scanner;

  localparam int N = 4;
  localparam int R = 4;
  localparam int FRAME = N * R;

  logic          clk;
  logic          rst;
  logic [15:0]   hex_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic          load;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_tick;

  seven_segment_scanner #(
    .NUM_DIGITS       (N),
    .REFRESH_DIV      (R),
    .ANODE_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: time since reset decides slot and digit; buffers are plain copies
  int          t;
  logic [15:0] m_sh_hex, m_act_hex;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_blank, m_act_blank;
  bit          m_sh_valid, m_act_valid;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_ft;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, got, exp, t, $time);
    end
  endtask

  task automatic model_edge();
    int   idx;
    bit   bnd;
    bit   blk;
    logic [3:0] nib;
    if (rst) begin
      t = 0;
      m_sh_hex = '0;  m_sh_dp = '0;  m_sh_blank = '1;  m_sh_valid = 0;
      m_act_hex = '0; m_act_dp = '0; m_act_blank = '1; m_act_valid = 0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
    end else begin
      idx   = (t / R) % N;
      bnd   = ((t % R) == R - 1) && (idx == N - 1);
      nib   = 4'((m_act_hex >> (4 * idx)) & 16'hF);
      blk   = m_act_blank[idx];
      e_seg = blk ? 7'h7F : seg_lut[nib];
      e_dp  = !(m_act_dp[idx] && !blk);
      e_an  = m_act_valid ? ~(4'b0001 << idx) : 4'hF;
      e_ft  = bnd;
      if (bnd) begin
        if (load) begin
          m_act_hex = hex_in; m_act_dp = dp_in; m_act_blank = blank_in; m_act_valid = 1;
        end else begin
          m_act_hex = m_sh_hex; m_act_dp = m_sh_dp; m_act_blank = m_sh_blank;
          m_act_valid = m_sh_valid;
        end
      end
      if (load) begin
        m_sh_hex = hex_in; m_sh_dp = dp_in; m_sh_blank = blank_in; m_sh_valid = 1;
      end
      t++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_seg", 32'(seg_out), 32'(e_seg));
    chk("model_dp", 32'(dp_out), 32'(e_dp));
    chk("model_an", 32'(an_out), 32'(e_an));
    chk("model_frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while ((t % FRAME) != p && n < 3 * FRAME) begin
      step();
      n++;
    end
    if ((t % FRAME) != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: phase %0d required %0d", t % FRAME, p);
    end
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    hex_in = h; dp_in = d; blank_in = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0]     hex;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;   // expected seg_out for slots 3..0
    logic [3:0]      dpo;   // expected dp_out for slots 3..0
  } vec_t;

  vec_t vecs [5];

  initial begin
    int ft_count;
    int lit_count;
    logic [3:0] an_exp;

    vecs[0] = '{16'h12AF, 4'b0100, 4'b0000,
                {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1011};
    vecs[1] = '{16'h3210, 4'b1111, 4'b1010,
                {7'b1111111, 7'b0100100, 7'b1111111, 7'b1000000}, 4'b1010};
    vecs[2] = '{16'hC9B4, 4'b0001, 4'b0100,
                {7'b1000110, 7'b1111111, 7'b0000011, 7'b0011001}, 4'b1110};
    vecs[3] = '{16'hED86, 4'b1000, 4'b0000,
                {7'b0000110, 7'b0100001, 7'b0000000, 7'b0000010}, 4'b0111};
    vecs[4] = '{16'h3579, 4'b0000, 4'b0000,
                {7'b0110000, 7'b0010010, 7'b1111000, 7'b0010000}, 4'b1111};

    rst = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;
    t = 0;
    step();
    step();
    chk("reset_seg", 32'(seg_out), 32'h7F);
    chk("reset_an", 32'(an_out), 32'hF);
    rst = 1'b0;

    // Three frames with no load: dark, frame_tick every 16 cycles
    ft_count = 0;
    lit_count = 0;
    repeat (3 * FRAME) begin
      step();
      if (frame_tick) ft_count++;
      if (an_out != 4'hF || seg_out != 7'h7F || dp_out != 1'b1) lit_count++;
    end
    chk("t1_frame_ticks", 32'(ft_count), 32'd3);
    chk("t1_dark_cycles", 32'(lit_count), 32'd0);
    $display("t1 reset/no-load: %0d frame ticks, %0d lit cycles", ft_count, lit_count);

    // Table vectors: load mid-frame, then check every slot of the following frame
    for (int v = 0; v < 5; v++) begin
      wait_phase(3 + 2 * v);
      do_load(vecs[v].hex, vecs[v].dp, vecs[v].blank);
      wait_phase(0);
      for (int s = 0; s < N; s++) begin
        step();
        an_exp = ~(4'b0001 << s);
        chk("tbl_seg", 32'(seg_out), 32'(vecs[v].seg[s]));
        chk("tbl_dp", 32'(dp_out), 32'(vecs[v].dpo[s]));
        chk("tbl_an", 32'(an_out), 32'(an_exp));
        repeat (R - 1) step();
      end
      $display("vector %0d hex=%h dp=%b blank=%b checked, errors so far %0d",
               v, vecs[v].hex, vecs[v].dp, vecs[v].blank, errors);
    end

    // Mid-frame update: the frame already showing 8888 completes unchanged
    do_load(16'h8888, 4'b0000, 4'b0000);
    wait_phase(0);
    wait_phase(5);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_phase(8);
    step();
    chk("t3_slot2_still8", 32'(seg_out), 32'b0000000);
    wait_phase(12);
    step();
    chk("t3_slot3_still8", 32'(seg_out), 32'b0000000);
    wait_phase(0);
    step();
    chk("t3_next_frame_seg", 32'(seg_out), 32'b1000000);
    chk("t3_next_frame_an", 32'(an_out), 32'b1110);
    $display("t3 mid-frame update checked, errors so far %0d", errors);

    // Load on the boundary cycle is visible in slot 0 of the new frame
    wait_phase(FRAME - 1);
    do_load(16'h5555, 4'b0000, 4'b0000);
    step();
    chk("t4_bypass_seg", 32'(seg_out), 32'b0010010);
    chk("t4_bypass_an", 32'(an_out), 32'b1110);
    $display("t4 boundary-cycle load checked, errors so far %0d", errors);

    // Reset during slot 2 discards everything; display stays dark afterwards
    do_load(16'h1234, 4'b1111, 4'b0000);
    step();
    wait_phase(0);
    wait_phase(9);
    rst = 1'b1;
    step();
    chk("t6_rst_seg", 32'(seg_out), 32'h7F);
    chk("t6_rst_dp", 32'(dp_out), 32'd1);
    chk("t6_rst_an", 32'(an_out), 32'hF);
    chk("t6_rst_ft", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    lit_count = 0;
    ft_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (an_out != 4'hF) lit_count++;
      if (frame_tick) begin
        ft_count++;
        chk("t6_ft_position", 32'(i % FRAME), 32'(FRAME - 1));
      end
    end
    chk("t6_no_redisplay", 32'(lit_count), 32'd0);
    chk("t6_ft_count", 32'(ft_count), 32'd2);
    $display("t6 reset mid-scan checked, errors so far %0d", errors);

    // Randomized traffic against the model, with occasional resets
    for (int i = 0; i < 1200; i++) begin
      load     = ($urandom_range(0, 5) == 0);
      hex_in   = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    $display("random phase done, errors so far %0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
